// File: rtl/line_window_ctrl.sv
// line_window_ctrl: steers a raster pixel stream into four external line buffers in rotation.
// Once three lines are held, it reads three buffers in lockstep and emits a registered 3x3
// window per cycle. o_intr pulses once per consumed line.
// Optional feature: define LWC_LINE_CNT_EN to add o_line_cnt, a 16-bit count of o_intr pulses.
module line_window_ctrl #(
  parameter int unsigned LINE_W = 512,
  parameter int unsigned CNT_W  = 9,
  parameter int unsigned FILL_W = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_valid,
  output logic [7:0]  o_lb_data,
  output logic [3:0]  o_lb_wr,
  output logic [3:0]  o_lb_rd,
  input  logic [23:0] i_lb0_data,
  input  logic [23:0] i_lb1_data,
  input  logic [23:0] i_lb2_data,
  input  logic [23:0] i_lb3_data,
  output logic [71:0] o_window,
  output logic        o_window_valid,
  output logic        o_intr
`ifdef LWC_LINE_CNT_EN
  ,
  output logic [15:0] o_line_cnt
`endif
);

  localparam logic [CNT_W-1:0]  LastCol    = CNT_W'(LINE_W - 1);
  localparam logic [FILL_W-1:0] FillThresh = FILL_W'(3 * LINE_W);

  typedef enum logic {StIdle, StRd} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_cnt_q;
  logic [1:0]         wr_sel_q;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [1:0]         rd_sel_q, rd_sel_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               intr_q, intr_d;
  logic [71:0]        window_q;
  logic               window_valid_q;
  logic               rd_active;
  logic [3:0]         rd_mask;
  logic [23:0]        lb_data [4];

  assign rd_active = (state_q == StRd);

  // Write strobe follows the pixel strobe combinationally into the current write buffer.
  always_comb begin
    o_lb_data = i_pixel_data;
    o_lb_wr   = i_pixel_valid ? (4'b0001 << wr_sel_q) : 4'b0000;
  end

  // Column counter and buffer select for the write side.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_cnt_q <= '0;
      wr_sel_q <= '0;
    end else if (i_pixel_valid) begin
      if (wr_cnt_q == LastCol) begin
        wr_cnt_q <= '0;
        wr_sel_q <= wr_sel_q + 2'd1;
      end else begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

  // Fill counts stored-but-unread pixels; simultaneous write and read cancel.
  always_comb begin
    fill_d = fill_q;
    if (i_pixel_valid && !rd_active) begin
      fill_d = fill_q + FILL_W'(1);
    end else if (!i_pixel_valid && rd_active) begin
      fill_d = fill_q - FILL_W'(1);
    end
  end

  // Read FSM next state: one line per RD visit, always returning through IDLE.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    rd_sel_d = rd_sel_q;
    intr_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (fill_q >= FillThresh) begin
          state_d = StRd;
        end
      end
      StRd: begin
        if (rd_cnt_q == LastCol) begin
          state_d  = StIdle;
          rd_cnt_d = '0;
          rd_sel_d = rd_sel_q + 2'd1;
          intr_d   = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read-side state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      rd_cnt_q <= '0;
      rd_sel_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      rd_sel_q <= rd_sel_d;
      fill_q   <= fill_d;
    end
  end

  // The three oldest lines start at rd_sel; the fourth buffer is the one being written.
  always_comb begin
    rd_mask = 4'b0111;
    case (rd_sel_q)
      2'd0: rd_mask = 4'b0111;
      2'd1: rd_mask = 4'b1110;
      2'd2: rd_mask = 4'b1101;
      2'd3: rd_mask = 4'b1011;
      default: rd_mask = 4'b0111;
    endcase
    o_lb_rd = rd_active ? rd_mask : 4'b0000;
  end

  assign lb_data[0] = i_lb0_data;
  assign lb_data[1] = i_lb1_data;
  assign lb_data[2] = i_lb2_data;
  assign lb_data[3] = i_lb3_data;

  // Window register: top row is the oldest line; the 2-bit index wraps mod 4.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      window_q       <= '0;
      window_valid_q <= 1'b0;
      intr_q         <= 1'b0;
    end else begin
      window_q       <= {lb_data[rd_sel_q], lb_data[rd_sel_q + 2'd1], lb_data[rd_sel_q + 2'd2]};
      window_valid_q <= rd_active;
      intr_q         <= intr_d;
    end
  end

  assign o_window       = window_q;
  assign o_window_valid = window_valid_q;
  assign o_intr         = intr_q;

`ifdef LWC_LINE_CNT_EN
  logic [15:0] line_cnt_q;

  // Consumed-line counter, stepping on the same edge that raises o_intr.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      line_cnt_q <= '0;
    end else if (intr_d) begin
      line_cnt_q <= line_cnt_q + 16'd1;
    end
  end

  assign o_line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl with a reduced line width. The four external line buffers are
// modelled as plain memories; expected behaviour comes from a pixel-history reference model.
module tb_line_window_ctrl;

  localparam int unsigned LW  = 64;
  localparam int unsigned CW  = 6;
  localparam int unsigned FW  = 9;
  localparam int          LWI = LW;

  logic        i_clk, i_rst;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_valid;
  logic [7:0]  o_lb_data;
  logic [3:0]  o_lb_wr, o_lb_rd;
  logic [23:0] i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data;
  logic [71:0] o_window;
  logic        o_window_valid, o_intr;
`ifdef LWC_LINE_CNT_EN
  logic [15:0] o_line_cnt;
`endif

  line_window_ctrl #(.LINE_W(LW), .CNT_W(CW), .FILL_W(FW)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pixel_data   (i_pixel_data),
    .i_pixel_valid  (i_pixel_valid),
    .o_lb_data      (o_lb_data),
    .o_lb_wr        (o_lb_wr),
    .o_lb_rd        (o_lb_rd),
    .i_lb0_data     (i_lb0_data),
    .i_lb1_data     (i_lb1_data),
    .i_lb2_data     (i_lb2_data),
    .i_lb3_data     (i_lb3_data),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .o_intr         (o_intr)
`ifdef LWC_LINE_CNT_EN
    ,
    .o_line_cnt     (o_line_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp, n_err;

  // External line buffer memories.
  logic [7:0] mem [4][LW];
  int         wptr [4];
  int         rptr [4];

  // Reference model: every pixel since reset, lines consumed, column within the current read.
  logic [7:0] hist [$];
  int         m_left, m_lines, m_col;
  logic       m_prev_act, m_prev_intr;
  logic [71:0] m_prev_win;
  bit         chk_data, chk_coll;
  int         intr_seen;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Three buffers starting at sel, as a one-hot-per-buffer mask.
  function automatic logic [3:0] rd_mask_of(int sel);
    int m;
    m = ((7 << sel) | (7 >> (4 - sel))) & 15;
    return 4'(m);
  endfunction

  function automatic logic [23:0] row_bytes(int row, int col);
    return {hist[row * LWI + (col % LWI)], hist[row * LWI + ((col + 1) % LWI)],
            hist[row * LWI + ((col + 2) % LWI)]};
  endfunction

  function automatic logic [71:0] exp_window(int line, int col);
    return {row_bytes(line, col), row_bytes(line + 1, col), row_bytes(line + 2, col)};
  endfunction

  function automatic logic [23:0] lb_out(int b);
    return {mem[b][rptr[b]], mem[b][(rptr[b] + 1) % LWI], mem[b][(rptr[b] + 2) % LWI]};
  endfunction

  task automatic drive_env();
    i_lb0_data = lb_out(0);
    i_lb1_data = lb_out(1);
    i_lb2_data = lb_out(2);
    i_lb3_data = lb_out(3);
  endtask

  task automatic model_reset();
    hist.delete();
    m_left      = 0;
    m_lines     = 0;
    m_col       = 0;
    m_prev_act  = 1'b0;
    m_prev_intr = 1'b0;
    m_prev_win  = '0;
    for (int b = 0; b < 4; b++) begin
      wptr[b] = 0;
      rptr[b] = 0;
    end
    drive_env();
  endtask

  // Hold reset for n edges, then check that every output and the fill count are cleared.
  task automatic do_reset(input int n);
    i_rst         = 1'b1;
    i_pixel_valid = 1'b0;
    i_pixel_data  = '0;
    repeat (n) @(posedge i_clk);
    #1;
    check_eq("rst_lb_wr", o_lb_wr, 4'b0);
    check_eq("rst_lb_rd", o_lb_rd, 4'b0);
    check_eq("rst_win_valid", o_window_valid, 1'b0);
    check_eq("rst_intr", o_intr, 1'b0);
    check_eq("rst_window", o_window, 72'h0);
    check_eq("rst_fill", dut.fill_q, 0);
`ifdef LWC_LINE_CNT_EN
    check_eq("rst_line_cnt", o_line_cnt, 16'd0);
`endif
    i_rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: apply inputs, compare against the model, advance model and buffers.
  task automatic step(input logic v, input logic [7:0] d);
    logic [3:0] wr_s, rd_s;
    int         fill_exp;
    logic       act;
    i_pixel_valid = v;
    i_pixel_data  = d;
    #1;
    fill_exp = hist.size() - (m_lines * LWI + m_col);
    act      = (m_left > 0);
    check_eq("lb_wr", o_lb_wr, v ? (4'b0001 << ((hist.size() / LWI) % 4)) : 4'b0);
    if (v) check_eq("lb_data", o_lb_data, d);
    check_eq("lb_rd", o_lb_rd, act ? rd_mask_of(m_lines % 4) : 4'b0);
    check_eq("win_valid", o_window_valid, m_prev_act);
    check_eq("intr", o_intr, m_prev_intr);
    if (m_prev_act && chk_data) check_eq("window", o_window, m_prev_win);
    check_eq("fill", dut.fill_q, fill_exp);
    if (chk_coll) check_eq("wr_rd_overlap", o_lb_wr & o_lb_rd, 4'b0);
`ifdef LWC_LINE_CNT_EN
    check_eq("line_cnt", o_line_cnt, 16'(m_lines));
`endif
    if (o_intr) intr_seen++;
    wr_s = o_lb_wr;
    rd_s = o_lb_rd;
    @(posedge i_clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      if (wr_s[b]) begin
        mem[b][wptr[b]] = d;
        wptr[b] = (wptr[b] + 1) % LWI;
      end
      if (rd_s[b]) rptr[b] = (rptr[b] + 1) % LWI;
    end
    m_prev_act  = act;
    m_prev_intr = 1'b0;
    if (act) begin
      if (chk_data) m_prev_win = exp_window(m_lines, m_col);
      m_col++;
      m_left--;
      if (m_left == 0) begin
        m_prev_intr = 1'b1;
        m_lines++;
        m_col = 0;
      end
    end else if (fill_exp >= 3 * LWI) begin
      m_left = LWI;
    end
    if (v) hist.push_back(d);
    drive_env();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    intr_seen = 0;
    chk_data = 1'b1;
    chk_coll = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < LWI; c++) mem[b][c] = '0;
    model_reset();
    do_reset(3);

    // Fill three lines with the pixel strobe toggling 1,0.
    for (int i = 0; i < 3 * LWI; i++) begin
      step(1'b1, 8'($urandom));
      step(1'b0, 8'h00);
    end

    // Write exactly on every read cycle: fill holds, writes avoid the buffers being read.
    for (int i = 0; i < 4 * (LWI + 1) + 2; i++) step(m_left > 0, 8'($urandom));

    // Random strobe at roughly half rate.
    for (int i = 0; i < 12 * LWI; i++) step(1'($urandom), 8'($urandom));

    for (int i = 0; i < 2 * LWI; i++) step(1'b0, 8'h00);

    // Stream until a read reaches column 40, then reset in the middle of the line.
    for (int i = 0; i < 4 * LWI && !(m_left > 0 && m_col == 40); i++) step(1'b1, 8'($urandom));
    check_eq("rd_col_before_rst", dut.rd_cnt_q, 40);
    do_reset(1);

    // Restream three lines; the first read must start again at buffer 0.
    for (int i = 0; i < 3 * LWI; i++) step(1'b1, 8'($urandom));
    for (int i = 0; i < LWI + 4; i++) step(1'b0, 8'h00);

    // Continuous full frame; buffers may be overrun, so window data is not compared here.
    do_reset(2);
    chk_data  = 1'b0;
    chk_coll  = 1'b0;
    intr_seen = 0;
    for (int i = 0; i < LWI * LWI; i++) step(1'b1, 8'($urandom));
    for (int i = 0; i < 4 * LWI; i++) step(1'b0, 8'h00);
    check_eq("frame_intr_total", intr_seen, LWI - 2);
    check_eq("frame_final_fill", dut.fill_q, 2 * LWI);
`ifdef LWC_LINE_CNT_EN
    check_eq("frame_line_cnt", o_line_cnt, 16'(LWI - 2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
